wb_branch_ctrl: RTL
===================

Name: wb_branch_ctrl

Overview:
- Control-flow controller at the WB stage of the LC-3b pipeline.
- Owns the architectural condition-code register and resolves BR/JMP/JSR/TRAP using the instruction retiring in WB.
- Issues a held redirect (target PC plus pcmux select) to fetch, then sequences a counted flush of the younger pipeline stages.
- The WB datapath supplies wbdata, br_addr and ipacket fields; this block decides whether the pipeline continues sequentially or is squashed.

Parameters:
- FLUSH_STAGES, 3: number of cycles flush is held after fetch accepts the redirect (one per younger stage: IF/ID, ID/EX, EX/MEM).
- CNT_W, 2: width of the drain counter; must satisfy 2^CNT_W > FLUSH_STAGES.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB holds a real (non-bubble) instruction
- wb_opcode  in  4  lc3b_opcode of the WB instruction
- wb_nzp  in  3  BR condition field
- wb_load_cc  in  1  instruction writes CC
- wb_pcmux_sel  in  2  decoded target select from the ipacket
- wbdata  in  16  value written back; source for CC generation
- br_addr  in  16  computed branch/jump target
- stall  in  1  pipeline stalled this cycle
- redirect_ack  in  1  fetch consumed the redirect
- cc  out  3  current NZP
- redirect_valid  out  1  redirect request pending
- redirect_pc  out  16  latched target
- pcmux_sel  out  2  PC mux select to fetch
- flush  out  1  squash younger stages
- busy  out  1  controller not IDLE

Behaviour:
Reset values (asynchronous, on reset_n low): state=IDLE, cc=3'b010, redirect_valid=0, redirect_pc=0, pcmux_sel=2'b00, flush=0, busy=0, drain counter=0.

Retire condition: `ret = wb_valid && !stall && state==IDLE`.

CC update:
- On ret with wb_load_cc, cc <= gencc(wbdata).
- gencc: n = bit 15; z = (wbdata==0); p otherwise.
- Exactly one bit is set.

Taken rule (combinational, uses the cc register value before any same-cycle update):
- BR (0000): taken iff (wb_nzp & cc) != 0. nzp=000 is never taken; nzp=111 is always taken.
- JMP (1100), JSR (0100), TRAP (1111): always taken.
- All other opcodes: never taken.

FSM:
- IDLE
  - On ret && taken: redirect_pc <= br_addr, pcmux_sel <= wb_pcmux_sel, go to REDIRECT.
  - Otherwise stay in IDLE; pcmux_sel=00.
- REDIRECT
  - redirect_valid=1, flush=1, busy=1.
  - Outputs are held stable until redirect_ack. stall has no effect on them.
  - redirect_ack is sampled only in REDIRECT, so it is never seen in the IDLE->REDIRECT transition cycle.
  - On ack: counter <= FLUSH_STAGES-1, go to DRAIN.
  - redirect_valid deasserts in the cycle after ack.
- DRAIN
  - flush=1, busy=1, redirect_valid=0, pcmux_sel=00.
  - Counter decrements each cycle; when it reaches 0, go to IDLE.
  - Total flush cycles after ack = FLUSH_STAGES.
- In REDIRECT and DRAIN, wb_valid is ignored: squashed instructions never update CC and never redirect.

Latency:
- Taken instruction at cycle t gives redirect_valid=1 at t+1.
- A non-taken instruction adds zero bubbles.

Stall:
- Stall in IDLE suppresses retirement.
- A branch held under stall is evaluated on the first unstalled cycle, using cc at that time.

Reset mid-operation: returns to IDLE immediately and drops flush/redirect_valid asynchronously.

Back-to-back: a CC-writing instruction followed next cycle by BR uses the updated cc, because the register has loaded by then.

Decomposition:
- lc3b_types package:
  - opcode constants op_br, op_jmp, op_jsr, op_trap
  - lc3b_nzp, lc3b_word, lc3b_opcode
  - new enum wbctl_state_t {IDLE, REDIRECT, DRAIN}
- One sub-module: gencc (combinational, 16 -> 3), shared with any future CC consumer.
- The taken comparison is inline (equivalent to cccomp).

Test Plan:
1. Reset deasserted -> cc=010, all outputs 0. Then retire ADD with load_cc, wbdata=16'h8000 -> cc=100 next cycle, redirect_valid stays 0.
2. With cc=010, retire BR nzp=010, br_addr=16'h3040, pcmux_sel=01 -> next cycle redirect_valid=1, redirect_pc=3040, pcmux_sel=01, flush=1.
   - Hold ack low for 4 cycles: outputs stay stable.
   - Assert ack: flush stays high for exactly 3 further cycles, then busy=0.
3. BR nzp=101 with cc=010 -> no redirect, no flush. BR nzp=000 -> never taken. BR nzp=111 -> taken.
4. JMP under stall=1 for 2 cycles -> no action while stalled; redirect issued one cycle after stall drops.
5. During DRAIN, present wb_valid=1, wb_load_cc=1, wbdata=0, and a TRAP -> cc unchanged, no second redirect.
6. reset_n pulsed low mid-REDIRECT -> redirect_valid and flush fall without waiting for clk; state returns to IDLE and cc=010.

Source files
------------

// File: rtl/wb_branch_ctrl_pkg.sv
// LC-3b shared types: opcode encodings, word/CC types and the WB control-flow FSM states.
// The bundle's other files import this package as lc3b_types.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [2:0]  lc3b_nzp;

    localparam lc3b_opcode op_br   = 4'b0000;
    localparam lc3b_opcode op_jsr  = 4'b0100;
    localparam lc3b_opcode op_jmp  = 4'b1100;
    localparam lc3b_opcode op_trap = 4'b1111;

    localparam lc3b_nzp CC_RESET = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        DRAIN
    } wbctl_state_t;

endpackage

// File: rtl/wb_branch_ctrl_if.sv
// WB-stage control-flow bundle: retiring instruction fields in, redirect/flush/CC out.
interface wb_branch_ctrl_if;
    import lc3b_types::*;

    logic       wb_valid;
    lc3b_opcode wb_opcode;
    lc3b_nzp    wb_nzp;
    logic       wb_load_cc;
    logic [1:0] wb_pcmux_sel;
    lc3b_word   wbdata;
    lc3b_word   br_addr;
    logic       stall;
    logic       redirect_ack;

    lc3b_nzp    cc;
    logic       redirect_valid;
    lc3b_word   redirect_pc;
    logic [1:0] pcmux_sel;
    logic       flush;
    logic       busy;

    modport slave (
        input  wb_valid, wb_opcode, wb_nzp, wb_load_cc, wb_pcmux_sel,
               wbdata, br_addr, stall, redirect_ack,
        output cc, redirect_valid, redirect_pc, pcmux_sel, flush, busy
    );

    modport master (
        output wb_valid, wb_opcode, wb_nzp, wb_load_cc, wb_pcmux_sel,
               wbdata, br_addr, stall, redirect_ack,
        input  cc, redirect_valid, redirect_pc, pcmux_sel, flush, busy
    );

endinterface

// File: rtl/wb_branch_ctrl_gencc.sv
// Condition-code generator: maps a 16-bit result to a one-hot NZP value.
module gencc
    import lc3b_types::*;
(
    input  lc3b_word data,
    output lc3b_nzp  nzp
);

    always_comb begin
        nzp = 3'b001;
        if (data[15]) begin
            nzp = 3'b100;
        end else if (data == 16'h0000) begin
            nzp = 3'b010;
        end
    end

endmodule

// File: rtl/wb_branch_ctrl.sv
// WB-stage control-flow controller: owns CC, resolves BR/JMP/JSR/TRAP, issues a held
// redirect to fetch and then drains the younger stages with a counted flush.
module wb_branch_ctrl
    import lc3b_types::*;
#(
    parameter int FLUSH_STAGES = 3,
    parameter int CNT_W        = 2
) (
    input logic              clk,
    input logic              reset_n,
    wb_branch_ctrl_if.slave  bus
);

    wbctl_state_t state_q, state_d;
    lc3b_nzp      cc_q, cc_d;
    lc3b_word     redirect_pc_q, redirect_pc_d;
    logic [1:0]   pcmux_sel_q, pcmux_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    lc3b_nzp gen_cc;
    logic    ret;
    logic    taken;

    gencc u_gencc (
        .data (bus.wbdata),
        .nzp  (gen_cc)
    );

    // Taken decision looks at the registered CC, never the value being written this cycle.
    always_comb begin
        taken = 1'b0;
        case (bus.wb_opcode)
            op_br:                   taken = |(bus.wb_nzp & cc_q);
            op_jmp, op_jsr, op_trap: taken = 1'b1;
            default:                 taken = 1'b0;
        endcase
    end

    assign ret = bus.wb_valid && !bus.stall && (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        cc_d          = cc_q;
        redirect_pc_d = redirect_pc_q;
        pcmux_sel_d   = pcmux_sel_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (ret && bus.wb_load_cc) begin
                    cc_d = gen_cc;
                end
                if (ret && taken) begin
                    redirect_pc_d = bus.br_addr;
                    pcmux_sel_d   = bus.wb_pcmux_sel;
                    state_d       = REDIRECT;
                end
            end
            REDIRECT: begin
                if (bus.redirect_ack) begin
                    cnt_d   = CNT_W'(FLUSH_STAGES - 1);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cc_q          <= CC_RESET;
            redirect_pc_q <= '0;
            pcmux_sel_q   <= 2'b00;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cc_q          <= cc_d;
            redirect_pc_q <= redirect_pc_d;
            pcmux_sel_q   <= pcmux_sel_d;
            cnt_q         <= cnt_d;
        end
    end

    // Outputs decode straight from state so an async reset drops them without a clock.
    assign bus.cc             = cc_q;
    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.pcmux_sel      = (state_q == REDIRECT) ? pcmux_sel_q : 2'b00;
    assign bus.flush          = (state_q != IDLE);
    assign bus.busy           = (state_q != IDLE);

endmodule
